vram_port_arbiter: RTL

VRAM_PORT_ARBITER -- requirements
Module: vram_port_arbiter

---
 rtl/vram_port_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares one VRAM port between a host bus and a block-fill engine.
// Host requests win by default. The fill engine gets the port when the host is idle,
// or once the host has won STARVE_MAX consecutive fill cycles.
// Optional build macro VRAM_FILL_VSYNC_EN: an armed fill waits for VSYNC_PULSE before writing.
module vram_port_arbiter #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              HOST_READ,
  input  logic              HOST_WRITE,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [3:0]        HOST_BYTE_EN,
  input  logic [31:0]       HOST_WRITEDATA,
  output logic              HOST_WAITREQUEST,
  output logic [31:0]       HOST_READDATA,
  output logic              HOST_READDATAVALID,
  input  logic              FILL_START,
  input  logic [ADDR_W-1:0] FILL_BASE,
  input  logic [ADDR_W:0]   FILL_COUNT,
  input  logic [31:0]       FILL_DATA,
  input  logic              VSYNC_PULSE,
  output logic              FILL_BUSY,
  output logic              FILL_DONE,
  output logic [ADDR_W-1:0] VRAM_ADDR,
  output logic [31:0]       VRAM_WDATA,
  output logic [3:0]        VRAM_BYTE_EN,
  output logic              VRAM_WREN,
  output logic              VRAM_REN,
  input  logic [31:0]       VRAM_RDATA
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ARMED, FILL, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       data_q, data_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              rvalid_q;
  logic              host_req;
  logic              fill_grant;
  logic              host_grant;

`ifndef VRAM_FILL_VSYNC_EN
  // Frame strobe has no role when fills start immediately.
  logic vsync_unused;
  assign vsync_unused = VSYNC_PULSE;
`endif

  // Grant decision; a fill write is suppressed in the reset cycle so an abort issues no write.
  always_comb begin
    host_req   = HOST_READ | HOST_WRITE;
    fill_grant = (state_q == FILL) && !RESET && (!host_req || (starve_q == STV_MAX));
    host_grant = host_req && !fill_grant;
  end

  // State and fill-context registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      data_q   <= '0;
      starve_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      starve_q <= starve_d;
      rvalid_q <= host_grant && HOST_READ && !HOST_WRITE;
    end
  end

  // Next-state, fill address/count stepping and starvation counting.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    data_d   = data_q;
    starve_d = '0;
    case (state_q)
      IDLE: begin
        if (FILL_START) begin
          addr_d  = FILL_BASE;
          count_d = FILL_COUNT;
          data_d  = FILL_DATA;
          state_d = ARMED;
        end
      end
      ARMED: begin
`ifdef VRAM_FILL_VSYNC_EN
        if (VSYNC_PULSE) begin
          state_d = (count_q == '0) ? DONE : FILL;
        end
`else
        state_d = (count_q == '0) ? DONE : FILL;
`endif
      end
      FILL: begin
        if (fill_grant) begin
          addr_d  = ADDR_W'(addr_q + ADDR_W'(1));
          count_d = CNT_W'(count_q - CNT_W'(1));
          if (count_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end else if (host_req) begin
          starve_d = (starve_q == STV_MAX) ? starve_q : STV_W'(starve_q + STV_W'(1));
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // VRAM port mux: fill write, host pass-through (read+write is a write), or quiet.
  always_comb begin
    VRAM_ADDR    = '0;
    VRAM_WDATA   = '0;
    VRAM_BYTE_EN = '0;
    VRAM_WREN    = 1'b0;
    VRAM_REN     = 1'b0;
    if (fill_grant) begin
      VRAM_ADDR    = addr_q;
      VRAM_WDATA   = data_q;
      VRAM_BYTE_EN = 4'hF;
      VRAM_WREN    = 1'b1;
    end else if (host_grant) begin
      VRAM_ADDR    = HOST_ADDR;
      VRAM_WDATA   = HOST_WRITEDATA;
      VRAM_BYTE_EN = HOST_BYTE_EN;
      VRAM_WREN    = HOST_WRITE;
      VRAM_REN     = HOST_READ && !HOST_WRITE;
    end
  end

  assign HOST_WAITREQUEST   = host_req && fill_grant;
  assign HOST_READDATA      = VRAM_RDATA;
  assign HOST_READDATAVALID = rvalid_q;
  assign FILL_BUSY          = (state_q != IDLE);
  assign FILL_DONE          = (state_q == DONE);

endmodule
